ibuffer_mw: RTL and testbench

Parametrised multi-issue instruction buffer between the fetch arbiter and decode. It accepts one full cache line of instructions per cycle, or the tail of a line after a redirect into mid-line. Each instruction is tagged with its PC. Decode can take up to DEQ_W instructions per cycle in order, and the block raises a one-cycle refill pulse when occupancy falls to the refill threshold.

---
 rtl/ibuf_pkg.sv | 25 ++
 rtl/ibuffer_mw_if.sv | 38 +++
 rtl/ibuf_array.sv | 51 +++++
 rtl/ibuffer_mw.sv | 122 ++++++++++++
 tb/tb_ibuffer_mw.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ibuf_pkg.sv
// ============================================================================
// Module  : ibuf_pkg
// Brief   : Shared defaults, entry type and pointer-width helper for ibuffer_mw
// Revision: 1.0
// ============================================================================
`default_nettype none

package ibuf_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 64;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } ibuf_entry_t;

    // Pointer width for a power-of-2 ring; never zero so degenerate sizes still elaborate.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibuffer_mw_if.sv
// ============================================================================
// Module  : ibuffer_mw_if
// Brief   : Line-fill and multi-issue dequeue bus of the instruction buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ibuffer_mw_if
    import ibuf_pkg::*;
#(
    parameter int INST_W     = INST_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int LINE_INSTS = 16,
    parameter int DEQ_W      = 2
);
    logic                               line_valid;
    logic                               line_ready;
    logic [LINE_INSTS*INST_W-1:0]       line_data;
    logic [PC_W-1:0]                    line_pc;
    logic [$clog2(LINE_INSTS)-1:0]      line_offset;
    logic [DEQ_W-1:0]                   deq_valid;
    logic [DEQ_W*INST_W-1:0]            deq_inst;
    logic [DEQ_W*PC_W-1:0]              deq_pc;
    logic [$clog2(DEQ_W+1)-1:0]         deq_take;

    modport master (
        output line_valid, line_data, line_pc, line_offset, deq_take,
        input  line_ready, deq_valid, deq_inst, deq_pc
    );

    modport slave (
        input  line_valid, line_data, line_pc, line_offset, deq_take,
        output line_ready, deq_valid, deq_inst, deq_pc
    );

endinterface

`default_nettype wire

// File: rtl/ibuf_array.sv
// ============================================================================
// Module  : ibuf_array
// Brief   : DEPTH-entry {inst, pc} storage, LINE_INSTS write ports, DEQ_W reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module ibuf_array
    import ibuf_pkg::*;
#(
    parameter int INST_W     = INST_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int DEPTH      = 32,
    parameter int LINE_INSTS = 16,
    parameter int DEQ_W      = 2,
    parameter int PTR_W      = ptr_w(DEPTH)
) (
    input  wire logic                               clk,
    input  wire logic [LINE_INSTS-1:0]              i_we,
    input  wire logic [LINE_INSTS-1:0][PTR_W-1:0]   i_waddr,
    input  wire logic [LINE_INSTS-1:0][INST_W-1:0]  i_winst,
    input  wire logic [LINE_INSTS-1:0][PC_W-1:0]    i_wpc,
    input  wire logic [DEQ_W-1:0][PTR_W-1:0]        i_raddr,
    output logic      [DEQ_W-1:0][INST_W-1:0]       o_rinst,
    output logic      [DEQ_W-1:0][PC_W-1:0]         o_rpc
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t r_mem [DEPTH];

    // Enabled ports always target distinct addresses, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LINE_INSTS; k++) begin
            if (i_we[k]) begin
                r_mem[i_waddr[k]] <= '{inst: i_winst[k], pc: i_wpc[k]};
            end
        end
    end

    for (genvar i = 0; i < DEQ_W; i++) begin : g_rd
        assign o_rinst[i] = r_mem[i_raddr[i]].inst;
        assign o_rpc[i]   = r_mem[i_raddr[i]].pc;
    end

endmodule

`default_nettype wire

// File: rtl/ibuffer_mw.sv
// ============================================================================
// Module  : ibuffer_mw
// Brief   : Multi-issue instruction buffer: line fill, in-order dequeue, refill pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module ibuffer_mw
    import ibuf_pkg::*;
#(
    parameter int INST_W        = INST_W_DEF,
    parameter int PC_W          = PC_W_DEF,
    parameter int LINE_INSTS    = 16,
    parameter int DEPTH         = 32,
    parameter int DEQ_W         = 2,
    parameter int REFILL_THRESH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    ibuffer_mw_if.slave                     bus,
    input  wire logic                       flush,
    output logic                            fetch_req,
    output logic [$clog2(DEPTH+1)-1:0]      level
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH+1);
    localparam int OFF_W  = $clog2(LINE_INSTS);
    localparam int TAKE_W = $clog2(DEQ_W+1);

    logic [PTR_W-1:0]   r_head, r_tail;
    logic [LVL_W-1:0]   r_level;
    logic               r_fetch_req;

    logic               w_ready, w_accept;
    logic [LVL_W-1:0]   w_n, w_enq, w_level_next;
    logic [TAKE_W-1:0]  w_avail, w_take;

    logic [LINE_INSTS-1:0]              w_we;
    logic [LINE_INSTS-1:0][PTR_W-1:0]   w_waddr;
    logic [LINE_INSTS-1:0][INST_W-1:0]  w_winst;
    logic [LINE_INSTS-1:0][PC_W-1:0]    w_wpc;
    logic [DEQ_W-1:0][PTR_W-1:0]        w_raddr;
    logic [DEQ_W-1:0][INST_W-1:0]       w_rinst;
    logic [DEQ_W-1:0][PC_W-1:0]         w_rpc;

    // Ready looks only at current occupancy; same-cycle dequeues earn no credit.
    assign w_ready      = !flush && ((LVL_W'(DEPTH) - r_level) >= LVL_W'(LINE_INSTS));
    assign w_accept     = bus.line_valid && w_ready;
    assign w_n          = LVL_W'(LINE_INSTS) - LVL_W'(bus.line_offset);
    assign w_enq        = w_accept ? w_n : '0;
    assign w_avail      = (r_level >= LVL_W'(DEQ_W)) ? TAKE_W'(DEQ_W) : TAKE_W'(r_level);
    assign w_take       = flush ? '0 : ((bus.deq_take > w_avail) ? w_avail : bus.deq_take);
    assign w_level_next = r_level + w_enq - LVL_W'(w_take);

    assign bus.line_ready = w_ready;
    assign fetch_req      = r_fetch_req;
    assign level          = r_level;

    for (genvar k = 0; k < LINE_INSTS; k++) begin : g_wr
        assign w_we[k]    = w_accept && (OFF_W'(k) >= bus.line_offset);
        assign w_waddr[k] = r_tail + PTR_W'(k) - PTR_W'(bus.line_offset);
        assign w_winst[k] = bus.line_data[k*INST_W +: INST_W];
        assign w_wpc[k]   = bus.line_pc + PC_W'(4 * k);
    end

    for (genvar i = 0; i < DEQ_W; i++) begin : g_deq
        assign w_raddr[i]                      = r_head + PTR_W'(i);
        assign bus.deq_valid[i]                = !flush && (r_level > LVL_W'(i));
        assign bus.deq_inst[i*INST_W +: INST_W] = w_rinst[i];
        assign bus.deq_pc[i*PC_W +: PC_W]       = w_rpc[i];
    end

    ibuf_array #(
        .INST_W     (INST_W),
        .PC_W       (PC_W),
        .DEPTH      (DEPTH),
        .LINE_INSTS (LINE_INSTS),
        .DEQ_W      (DEQ_W),
        .PTR_W      (PTR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_winst (w_winst),
        .i_wpc   (w_wpc),
        .i_raddr (w_raddr),
        .o_rinst (w_rinst),
        .o_rpc   (w_rpc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_level     <= '0;
            r_fetch_req <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_level     <= '0;
            r_fetch_req <= 1'b0;
        end else begin
            r_head      <= r_head + PTR_W'(w_take);
            r_tail      <= r_tail + PTR_W'(w_enq);
            r_level     <= w_level_next;
            r_fetch_req <= (r_level > LVL_W'(REFILL_THRESH)) &&
                           (w_level_next <= LVL_W'(REFILL_THRESH));
        end
    end

    // Decode must never consume more entries than it was shown.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (bus.deq_take <= w_avail)
                else $error("ibuffer_mw: deq_take %0d exceeds available %0d", bus.deq_take, w_avail);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibuffer_mw.sv
// ============================================================================
// Module  : tb_ibuffer_mw
// Brief   : Directed and random checks of ibuffer_mw against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ibuffer_mw;

    localparam int INST_W        = 32;
    localparam int PC_W          = 64;
    localparam int LINE_INSTS    = 16;
    localparam int DEPTH         = 32;
    localparam int DEQ_W         = 2;
    localparam int REFILL_THRESH = 4;
    localparam int LVL_W         = $clog2(DEPTH+1);

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               fetch_req;
    logic [LVL_W-1:0]   level;

    ibuffer_mw_if #(.INST_W(INST_W), .PC_W(PC_W), .LINE_INSTS(LINE_INSTS), .DEQ_W(DEQ_W)) bus ();

    ibuffer_mw #(
        .INST_W(INST_W), .PC_W(PC_W), .LINE_INSTS(LINE_INSTS),
        .DEPTH(DEPTH), .DEQ_W(DEQ_W), .REFILL_THRESH(REFILL_THRESH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .fetch_req (fetch_req),
        .level     (level)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    bit   exp_fetch = 1'b0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("level", 64'(level), 64'(q.size()));
        chk("fetch_req", 64'(fetch_req), 64'(exp_fetch));
        for (int i = 0; i < DEQ_W; i++) begin
            chk("deq_valid", 64'(bus.deq_valid[i]), 64'(i < q.size()));
            if (i < q.size()) begin
                chk("deq_pc", 64'(bus.deq_pc[i*PC_W +: PC_W]), 64'(q[i].pc));
                chk("deq_inst", 64'(bus.deq_inst[i*INST_W +: INST_W]), 64'(q[i].inst));
            end
        end
    endtask

    // One clock: drive at negedge, check ready, update model, check after the edge.
    task automatic step(input bit v, input logic [PC_W-1:0] pc, input int off,
                        input bit fl, input int take);
        bit exp_ready;
        int old;
        bus.line_valid  = v;
        bus.line_pc     = pc;
        bus.line_offset = off[$clog2(LINE_INSTS)-1:0];
        bus.deq_take    = take[$clog2(DEQ_W+1)-1:0];
        flush           = fl;
        for (int k = 0; k < LINE_INSTS; k++) bus.line_data[k*INST_W +: INST_W] = $urandom;
        #1;
        exp_ready = !fl && ((DEPTH - q.size()) >= LINE_INSTS);
        chk("line_ready", 64'(bus.line_ready), 64'(exp_ready));
        old = q.size();
        if (fl) begin
            q.delete();
            exp_fetch = 1'b0;
        end else begin
            for (int t = 0; t < take; t++) void'(q.pop_front());
            if (v && exp_ready) begin
                for (int j = off; j < LINE_INSTS; j++)
                    q.push_back('{inst: bus.line_data[j*INST_W +: INST_W], pc: pc + 64'(4*j)});
            end
            exp_fetch = (old > REFILL_THRESH) && (q.size() <= REFILL_THRESH);
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && q.size() > 0; c++)
            step(0, '0, 0, 0, (q.size() >= DEQ_W) ? DEQ_W : q.size());
    endtask

    initial begin
        int pulses;
        bus.line_valid  = 1'b0;
        bus.line_data   = '0;
        bus.line_pc     = '0;
        bus.line_offset = '0;
        bus.deq_take    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_fetch", 64'(fetch_req), 64'd0);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("rst_ready", 64'(bus.line_ready), 64'd1);
        rst_n = 1'b1;

        // Full line from 0x1000
        step(1, 64'h1000, 0, 0, 0);
        chk("l16_level", 64'(level), 64'd16);
        chk("l16_pc0", 64'(bus.deq_pc[0 +: PC_W]), 64'h1000);
        chk("l16_pc1", 64'(bus.deq_pc[PC_W +: PC_W]), 64'h1004);
        chk("l16_valid", 64'(bus.deq_valid), 64'b11);

        // Drain 2 per cycle: exactly one refill pulse, right after 6 -> 4
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, '0, 0, 0, 2);
            if (fetch_req) pulses++;
            if (level == 4) chk("pulse_at_4", 64'(fetch_req), 64'd1);
        end
        chk("pulse_count", 64'(pulses), 64'd1);

        // Tail of a line after redirect
        step(1, 64'h2000, 13, 0, 0);
        chk("off13_level", 64'(level), 64'd3);
        chk("off13_pc0", 64'(bus.deq_pc[0 +: PC_W]), 64'h2034);
        chk("off13_nofetch", 64'(fetch_req), 64'd0);
        drain();

        // Ready boundary at 17 vs 16
        step(1, 64'h3000, 0, 0, 0);
        step(1, 64'h3040, 15, 0, 0);
        chk("b_level17", 64'(level), 64'd17);
        step(1, 64'h3080, 0, 0, 1);
        chk("b_level16", 64'(level), 64'd16);
        step(1, 64'h3080, 0, 0, 0);
        chk("b_level32", 64'(level), 64'd32);

        // Flush wins over a line and a dequeue
        step(1, 64'h5000, 0, 1, 2);
        chk("fl_level", 64'(level), 64'd0);
        chk("fl_valid", 64'(bus.deq_valid), 64'd0);

        // Park head/tail at 24, then a full line wraps the ring
        step(1, 64'h6000, 0, 0, 0);
        step(1, 64'h6040, 8, 0, 0);
        drain();
        step(1, 64'h7000, 0, 0, 0);
        chk("wrap_pc0", 64'(bus.deq_pc[0 +: PC_W]), 64'h7000);
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int maxt;
            maxt = (q.size() >= DEQ_W) ? DEQ_W : q.size();
            step($urandom_range(0, 3) != 0,
                 {32'($urandom), 32'($urandom)} & ~64'h3f,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LINE_INSTS-1)) : 0,
                 $urandom_range(0, 39) == 0,
                 int'($urandom_range(0, maxt)));
        end

        // Asynchronous reset mid-operation
        step(1, 64'h8000, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_level", 64'(level), 64'd0);
        chk("async_valid", 64'(bus.deq_valid), 64'd0);
        q.delete();
        exp_fetch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 64'h9000, 4, 0, 0);
        chk("post_rst_level", 64'(level), 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
